// File: rtl/uart_tx_queue_if.sv
// Producer/transmitter-side signal bundle of the UART transmit queue.
// The producer and bench drive the i* signals; the queue drives the o* signals.
interface uart_tx_queue_if #(
  parameter int ADDR_W = 4
);
  logic              iWR_EN;
  logic [7:0]        iWR_DATA;
  logic              iCLR_FLAGS;
  logic              iTX_FINISH;
  logic              oSEND;
  logic [7:0]        oTX_DATA;
  logic [ADDR_W:0]   oCOUNT;
  logic              oFULL;
  logic              oEMPTY;
  logic              oBUSY;
  logic              oOVERFLOW;
  logic              oTIMEOUT;

  modport master (
    output iWR_EN, iWR_DATA, iCLR_FLAGS, iTX_FINISH,
    input  oSEND, oTX_DATA, oCOUNT, oFULL, oEMPTY, oBUSY, oOVERFLOW, oTIMEOUT
  );

  modport slave (
    input  iWR_EN, iWR_DATA, iCLR_FLAGS, iTX_FINISH,
    output oSEND, oTX_DATA, oCOUNT, oFULL, oEMPTY, oBUSY, oOVERFLOW, oTIMEOUT
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO + one-at-a-time send sequencer for a UART transmitter; oSEND 2 clocks after a push into an idle empty queue.
// Producers are never stalled: pushes while full are dropped and flagged; a silent transmitter is abandoned after a timeout.
module uart_tx_queue #(
  parameter int ADDR_W       = 4,
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 131071
) (
  input  logic           clk_s,
  input  logic           rstn_s,
  uart_tx_queue_if.slave bus
);
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int CNT_MAX = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
  localparam int TW      = $clog2(CNT_MAX + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [TW-1:0]   GAP_LAST = TW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_SEND,
    S_WAIT,
    S_GAP
  } state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     tmr, tmr_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              fin_q;
  logic              push, pop, tmo_evt;

  // Full is the registered flag, so a pop in the same cycle cannot make room.
  assign push = bus.iWR_EN && !bus.oFULL;
  assign pop  = (state == S_POP);

  always_comb begin
    count_nxt = bus.oCOUNT;
    if (push && !pop) begin
      count_nxt = bus.oCOUNT + 1'b1;
    end else if (pop && !push) begin
      count_nxt = bus.oCOUNT - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    tmo_evt   = 1'b0;
    unique case (state)
      S_IDLE: if (!bus.oEMPTY) state_nxt = S_POP;
      S_POP:  state_nxt = S_SEND;
      S_SEND: begin
        state_nxt = S_WAIT;
        tmr_nxt   = '0;
      end
      S_WAIT: begin
        if (fin_q) begin
          tmr_nxt   = '0;
          state_nxt = (GAP_CLKS > 0) ? S_GAP : S_IDLE;
        end else if (tmr == TMO_LAST) begin
          tmo_evt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      S_GAP: begin
        if (tmr == GAP_LAST) state_nxt = S_IDLE;
        else                 tmr_nxt   = tmr + 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      state         <= S_IDLE;
      tmr           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fin_q         <= 1'b0;
      bus.oCOUNT    <= '0;
      bus.oFULL     <= 1'b0;
      bus.oEMPTY    <= 1'b1;
      bus.oSEND     <= 1'b0;
      bus.oTX_DATA  <= 8'hFF;
      bus.oBUSY     <= 1'b0;
      bus.oOVERFLOW <= 1'b0;
      bus.oTIMEOUT  <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      // Finish pulses are only meaningful while a frame is outstanding.
      fin_q <= bus.iTX_FINISH && (state == S_WAIT);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        bus.oTX_DATA <= mem[rd_ptr];
      end
      bus.oCOUNT    <= count_nxt;
      bus.oFULL     <= (count_nxt == FULL_CNT);
      bus.oEMPTY    <= (count_nxt == '0);
      bus.oSEND     <= (state_nxt == S_SEND);
      bus.oBUSY     <= (state_nxt != S_IDLE);
      bus.oOVERFLOW <= !bus.iCLR_FLAGS && (bus.oOVERFLOW || (bus.iWR_EN && bus.oFULL));
      bus.oTIMEOUT  <= !bus.iCLR_FLAGS && (bus.oTIMEOUT || tmo_evt);
    end
  end

  always_ff @(posedge clk_s) begin
    if (push) mem[wr_ptr] <= bus.iWR_DATA;
  end
endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: vector table, directed corner sequences and a randomized run against a queue-based model.
module tb_uart_tx_queue;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TO    = 50;
  localparam int GAPB  = 5;

  logic clk_s  = 1'b0;
  logic rstn_s = 1'b0;
  always #5 clk_s = ~clk_s;

  uart_tx_queue_if #(.ADDR_W(AW)) ifa ();
  uart_tx_queue_if #(.ADDR_W(AW)) ifb ();

  uart_tx_queue #(.ADDR_W(AW), .GAP_CLKS(0), .TIMEOUT_CLKS(TO)) dut_a (
    .clk_s (clk_s), .rstn_s(rstn_s), .bus(ifa)
  );
  uart_tx_queue #(.ADDR_W(AW), .GAP_CLKS(GAPB), .TIMEOUT_CLKS(TO)) dut_b (
    .clk_s (clk_s), .rstn_s(rstn_s), .bus(ifb)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ek    = 0;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       fin;
    logic       clr;
    logic       e_send;
    logic [7:0] e_data;
    logic [4:0] e_cnt;
    logic       e_busy;
    logic       e_empty;
  } vec_t;
  vec_t tv [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h, expected %0h", nm, ek, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_s);
    #1;
    ek++;
  endtask

  task automatic idle_in();
    ifa.iWR_EN = 1'b0; ifa.iWR_DATA = 8'h00; ifa.iCLR_FLAGS = 1'b0; ifa.iTX_FINISH = 1'b0;
    ifb.iWR_EN = 1'b0; ifb.iWR_DATA = 8'h00; ifb.iCLR_FLAGS = 1'b0; ifb.iTX_FINISH = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rstn_s = 1'b0;
    cyc();
    cyc();
    chk("rst_count", 32'(ifa.oCOUNT), 32'd0);
    chk("rst_empty", 32'(ifa.oEMPTY), 32'd1);
    chk("rst_full", 32'(ifa.oFULL), 32'd0);
    chk("rst_send", 32'(ifa.oSEND), 32'd0);
    chk("rst_data", 32'(ifa.oTX_DATA), 32'hFF);
    chk("rst_busy", 32'(ifa.oBUSY), 32'd0);
    chk("rst_ovf", 32'(ifa.oOVERFLOW), 32'd0);
    chk("rst_tmo", 32'(ifa.oTIMEOUT), 32'd0);
    rstn_s = 1'b1;
  endtask

  // reference model state for the randomized run
  logic [7:0] mq [$];
  logic [7:0] m_data;
  logic       m_idle, m_ovf, m_tmo;
  int         m_pop_at, m_done_at, m_tmo_at, m_fin_at;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, edge %0d", ek);
    $fatal(1);
  end

  initial begin
    int n0, s1, fin_at, ns;
    int st [$];
    logic [7:0] sd [$];

    tv[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hFF, 5'd1, 1'b0, 1'b0};
    tv[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 5'd1, 1'b1, 1'b0};
    tv[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b1};
    tv[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b1};
    tv[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b1};
    tv[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b1};
    tv[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0, 1'b1};
    tv[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0, 1'b1};

    // single byte: latency, pulse width, wait for finish
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ifa.iWR_EN = tv[i].wr; ifa.iWR_DATA = tv[i].wd;
      ifa.iTX_FINISH = tv[i].fin; ifa.iCLR_FLAGS = tv[i].clr;
      cyc();
      chk($sformatf("tv%0d_send", i), 32'(ifa.oSEND), 32'(tv[i].e_send));
      chk($sformatf("tv%0d_data", i), 32'(ifa.oTX_DATA), 32'(tv[i].e_data));
      chk($sformatf("tv%0d_cnt", i), 32'(ifa.oCOUNT), 32'(tv[i].e_cnt));
      chk($sformatf("tv%0d_busy", i), 32'(ifa.oBUSY), 32'(tv[i].e_busy));
      chk($sformatf("tv%0d_empty", i), 32'(ifa.oEMPTY), 32'(tv[i].e_empty));
    end
    idle_in();

    // fill, overflow, clear priority, timeout, full+pop, reset mid-WAIT
    do_reset();
    n0 = ek + 1;
    for (int i = 0; i < 17; i++) begin
      ifa.iWR_EN = 1'b1; ifa.iWR_DATA = 8'(i + 1);
      cyc();
    end
    chk("fill_cnt", 32'(ifa.oCOUNT), 32'd16);
    chk("fill_full", 32'(ifa.oFULL), 32'd1);
    chk("fill_ovf", 32'(ifa.oOVERFLOW), 32'd0);
    ifa.iWR_DATA = 8'h12; cyc();
    chk("drop_ovf", 32'(ifa.oOVERFLOW), 32'd1);
    chk("drop_cnt", 32'(ifa.oCOUNT), 32'd16);
    ifa.iWR_DATA = 8'h13; ifa.iCLR_FLAGS = 1'b1; cyc();
    chk("clrprio_ovf", 32'(ifa.oOVERFLOW), 32'd0);
    ifa.iCLR_FLAGS = 1'b0; ifa.iWR_DATA = 8'h14; cyc();
    chk("reflag_ovf", 32'(ifa.oOVERFLOW), 32'd1);
    idle_in();
    while (ek < n0 + 2 + TO) cyc();
    chk("pre_tmo", 32'(ifa.oTIMEOUT), 32'd0);
    chk("pre_tmo_busy", 32'(ifa.oBUSY), 32'd1);
    cyc();
    chk("tmo_set", 32'(ifa.oTIMEOUT), 32'd1);
    chk("tmo_idle", 32'(ifa.oBUSY), 32'd0);
    cyc();
    ifa.iWR_EN = 1'b1; ifa.iWR_DATA = 8'h55; cyc();
    idle_in();
    chk("tmo_next_send", 32'(ifa.oSEND), 32'd1);
    chk("tmo_next_data", 32'(ifa.oTX_DATA), 32'h02);
    chk("fullpop_cnt", 32'(ifa.oCOUNT), 32'd15);
    ifa.iCLR_FLAGS = 1'b1; cyc();
    ifa.iCLR_FLAGS = 1'b0;
    chk("clr_ovf", 32'(ifa.oOVERFLOW), 32'd0);
    chk("clr_tmo", 32'(ifa.oTIMEOUT), 32'd0);
    cyc();
    #2;
    rstn_s = 1'b0;
    #1;
    chk("arst_cnt", 32'(ifa.oCOUNT), 32'd0);
    chk("arst_busy", 32'(ifa.oBUSY), 32'd0);
    chk("arst_send", 32'(ifa.oSEND), 32'd0);
    chk("arst_data", 32'(ifa.oTX_DATA), 32'hFF);
    chk("arst_empty", 32'(ifa.oEMPTY), 32'd1);
    cyc();
    rstn_s = 1'b1;

    // streaming with a transmitter answering 20 clocks after each send
    do_reset();
    n0 = ek + 1;
    fin_at = -1;
    for (int i = 0; i < 320; i++) begin
      ifa.iWR_EN = (i < 10); ifa.iWR_DATA = 8'(8'h30 + i);
      ifa.iTX_FINISH = (ek + 1 == fin_at);
      cyc();
      if (ifa.oSEND) begin
        st.push_back(ek); sd.push_back(ifa.oTX_DATA);
        fin_at = ek + 20;
      end
    end
    idle_in();
    chk("stream_nsend", 32'(st.size()), 32'd10);
    if (st.size() == 10) begin
      chk("stream_first", 32'(st[0] - n0), 32'd2);
      for (int i = 0; i < 10; i++) chk($sformatf("stream_d%0d", i), 32'(sd[i]), 32'(8'h30 + i));
      for (int i = 1; i < 10; i++) chk($sformatf("stream_gap%0d", i), 32'(st[i] - st[i-1]), 32'd23);
    end

    // inter-frame gap on the second instance
    do_reset();
    st.delete(); sd.delete();
    fin_at = -1;
    for (int i = 0; i < 60; i++) begin
      ifb.iWR_EN = (i < 2); ifb.iWR_DATA = (i == 0) ? 8'hC1 : 8'hC2;
      ifb.iTX_FINISH = (ek + 1 == fin_at);
      cyc();
      if (ifb.oSEND) begin
        st.push_back(ek); sd.push_back(ifb.oTX_DATA);
        if (st.size() == 1) fin_at = ek + 10;
      end
    end
    idle_in();
    chk("gap_nsend", 32'(st.size()), 32'd2);
    if (st.size() == 2) begin
      chk("gap_delay", 32'(st[1] - (st[0] + 10)), 32'd8);
      chk("gap_data", 32'(sd[1]), 32'hC2);
    end

    // randomized run against the queue model
    do_reset();
    mq.delete();
    m_data = 8'hFF; m_idle = 1'b1; m_ovf = 1'b0; m_tmo = 1'b0;
    m_pop_at = -1; m_done_at = -1; m_tmo_at = -1; m_fin_at = -1;
    for (int i = 0; i < 3000; i++) begin
      int k, pre, pct, sel, d;
      logic wr, clr, tmo_evt, e_send;
      logic [7:0] wd;
      k   = ek + 1;
      pct = (i / 500 == 1) ? 60 : (i / 500 == 3) ? 95 : (i / 500 == 4) ? 5 : 25;
      wr  = ($urandom_range(0, 99) < pct);
      wd  = 8'($urandom);
      clr = ($urandom_range(0, 39) == 0);
      ifa.iWR_EN = wr; ifa.iWR_DATA = wd; ifa.iCLR_FLAGS = clr;
      ifa.iTX_FINISH = (k == m_fin_at);

      pre = mq.size(); e_send = 1'b0; tmo_evt = 1'b0;
      if (m_idle) begin
        if (pre > 0) begin m_idle = 1'b0; m_pop_at = k + 1; end
      end else if (k == m_pop_at) begin
        m_data = mq.pop_front(); e_send = 1'b1;
        sel = $urandom_range(0, 11);
        d = (sel == 0) ? 1 : (sel == 1) ? 49 : (sel == 2) ? 50 : (sel == 3) ? 51 :
            (sel == 4) ? 0 : $urandom_range(2, 30);
        m_fin_at = (d == 0) ? -1 : k + d;
        if (d >= 2 && d <= TO) m_done_at = k + d + 1;
        else begin m_done_at = k + 1 + TO; m_tmo_at = m_done_at; end
      end else if (k == m_done_at) begin
        m_idle = 1'b1;
      end
      if (k == m_tmo_at) tmo_evt = 1'b1;
      if (wr && pre < DEPTH) mq.push_back(wd);
      m_ovf = !clr && (m_ovf || (wr && pre == DEPTH));
      m_tmo = !clr && (m_tmo || tmo_evt);

      cyc();
      chk("rnd_send", 32'(ifa.oSEND), 32'(e_send));
      chk("rnd_data", 32'(ifa.oTX_DATA), 32'(m_data));
      chk("rnd_cnt", 32'(ifa.oCOUNT), 32'(mq.size()));
      chk("rnd_full", 32'(ifa.oFULL), 32'(mq.size() == DEPTH));
      chk("rnd_empty", 32'(ifa.oEMPTY), 32'(mq.size() == 0));
      chk("rnd_busy", 32'(ifa.oBUSY), 32'(!m_idle));
      chk("rnd_ovf", 32'(ifa.oOVERFLOW), 32'(m_ovf));
      chk("rnd_tmo", 32'(ifa.oTIMEOUT), 32'(m_tmo));
    end
    idle_in();
    ns = n_cmp;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ns, n_bad);
    $finish;
  end
endmodule
